// File: rtl/lutram_sync_fifo.sv
// lutram_sync_fifo
// ----------------
// Single-clock FIFO whose storage is distributed (LUT) RAM. The memory is
// written synchronously and read asynchronously at rd_ptr; the read word is
// captured into the q register on an accepted read. Status flags are decoded
// combinationally from the registered occupancy count, so they follow the
// accepting edge by one cycle.
//
// Build option (macro): LUTRAM_FIFO_OUT_REG_EN
//   defined   - a second register stage follows q/q_vld (read latency 2)
//   undefined - q/q_vld come straight from the capture register (latency 1)
//
// Parameters
//   DATA_WIDTH  bits per entry (>= 1)
//   ADDR_BITS   depth = 2**ADDR_BITS, legal 2..9
//   AFULL_TH    almost_full  when count >= AFULL_TH
//   AEMPTY_TH   almost_empty when count <= AEMPTY_TH
//
// Ports
//   clk           clock
//   reset_n       synchronous active-low reset
//   wren/wdata    write request and data
//   rden          read request
//   q/q_vld       read data and its one-cycle valid pulse
//   full/empty    count == depth / count == 0
//   almost_full   count >= AFULL_TH
//   almost_empty  count <= AEMPTY_TH
//   count         occupancy 0..depth
//   overflow      sticky, write while full
//   underflow     sticky, read while empty
//   err_clr       clears overflow/underflow (a coincident new error wins)

module lutram_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int AFULL_TH   = 2**ADDR_BITS - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wren,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rden,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  q_vld,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_BITS:0]    count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int                DEPTH     = 2**ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C  = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AFULL_C  = (ADDR_BITS+1)'(AFULL_TH);
    localparam logic [ADDR_BITS:0] AEMPTY_C = (ADDR_BITS+1)'(AEMPTY_TH);

    // ------------------------------------------------------------------
    // Storage: no reset so it maps onto LUTRAM.
    // ------------------------------------------------------------------
    (* ram_style = "distributed" *)
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]    count_q,  count_d;
    logic [DATA_WIDTH-1:0] q1_q,     q1_d;
    logic                  q1_vld_q, q1_vld_d;
    logic                  ovf_q,    ovf_d;
    logic                  udf_q,    udf_d;

    logic full_w, empty_w;
    logic wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] rd_word;

    // Flags come from the registered count only.
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // Acceptance uses the flags as they stand at the start of the cycle, so
    // a full FIFO accepts a read but drops a simultaneous write, and an empty
    // FIFO accepts a write but rejects a simultaneous read (no bypass).
    assign wr_acc = wren & ~full_w;
    assign rd_acc = rden & ~empty_w;

    // Asynchronous LUTRAM read.
    assign rd_word = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        q1_d     = q1_q;
        q1_vld_d = 1'b0;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;     // wraps naturally at depth
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            q1_d     = rd_word;
            q1_vld_d = 1'b1;
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Clear first, then set, so a coincident error event wins.
        if (err_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (wren & full_w) begin
            ovf_d = 1'b1;
        end
        if (rden & empty_w) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q1_q     <= '0;
            q1_vld_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q1_q     <= q1_d;
            q1_vld_q <= q1_vld_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

`ifdef LUTRAM_FIFO_OUT_REG_EN
    // Extra output stage to break the LUT-to-consumer path.
    logic [DATA_WIDTH-1:0] q2_q;
    logic                  q2_vld_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q2_q     <= '0;
            q2_vld_q <= 1'b0;
        end else begin
            q2_q     <= q1_q;
            q2_vld_q <= q1_vld_q;
        end
    end

    assign q     = q2_q;
    assign q_vld = q2_vld_q;
`else
    assign q     = q1_q;
    assign q_vld = q1_vld_q;
`endif

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_lutram_sync_fifo.sv
// Directed bench for lutram_sync_fifo (default parameters: 8 bits x 32).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// A queue scoreboard tracks contents, flags and the read output pipeline;
// directed steps add hand-computed constant checks on top.

module tb_lutram_sync_fifo;

`ifdef LUTRAM_FIFO_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n, wren, rden, err_clr;
    logic [7:0] wdata;
    logic [7:0] q;
    logic       q_vld, full, empty, almost_full, almost_empty;
    logic [5:0] count;
    logic       overflow, underflow;

    lutram_sync_fifo #(
        .DATA_WIDTH(8), .ADDR_BITS(5), .AFULL_TH(30), .AEMPTY_TH(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .wren(wren), .wdata(wdata), .rden(rden),
        .q(q), .q_vld(q_vld), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // scoreboard state
    logic [7:0] sb[$];
    logic [7:0] got[$];
    logic [7:0] m_q1, m_q2;
    logic       m_v1, m_v2, m_ovf, m_udf;
    int         n_wr_acc, n_rd_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_q1 = '0; m_q2 = '0; m_v1 = 1'b0; m_v2 = 1'b0;
        m_ovf = 1'b0; m_udf = 1'b0;
    endtask

    task automatic sb_checks();
        chk("q_vld", 32'(q_vld), 32'((LAT == 2) ? m_v2 : m_v1));
        chk("q",     32'(q),     32'((LAT == 2) ? m_q2 : m_q1));
        chk("count", 32'(count), 32'(sb.size()));
        chk("full",  32'(full),  32'(sb.size() == 32));
        chk("empty", 32'(empty), 32'(sb.size() == 0));
        chk("ovf",   32'(overflow),  32'(m_ovf));
        chk("udf",   32'(underflow), 32'(m_udf));
    endtask

    // One clock: apply inputs, update the model, advance an edge, check.
    task automatic tick(input logic wr, input logic [7:0] wd, input logic rd, input logic clr);
        logic m_full, m_empty, rd_ok, wr_ok;
        logic [7:0] popped;
        wren = wr; wdata = wd; rden = rd; err_clr = clr;
        m_full  = (sb.size() == 32);
        m_empty = (sb.size() == 0);
        rd_ok = rd && !m_empty;
        wr_ok = wr && !m_full;
        popped = m_q1;
        if (rd_ok) begin popped = sb.pop_front(); n_rd_acc++; end
        if (wr_ok) begin sb.push_back(wd); n_wr_acc++; end
        m_q2 = m_q1; m_v2 = m_v1;
        m_v1 = rd_ok;
        if (rd_ok) m_q1 = popped;
        if (clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
        if (wr && m_full)  m_ovf = 1'b1;
        if (rd && m_empty) m_udf = 1'b1;
        @(posedge clk); #1;
        wren = 1'b0; rden = 1'b0; err_clr = 1'b0;
        if (q_vld) got.push_back(q);
        sb_checks();
    endtask

    task automatic do_reset();
        reset_n = 1'b0; wren = 1'b0; rden = 1'b0; err_clr = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [7:0] exp4 [4];
        reset_n = 1'b0; wren = 1'b0; rden = 1'b0; err_clr = 1'b0; wdata = '0;
        model_reset();
        n_wr_acc = 0; n_rd_acc = 0;
        @(posedge clk); #1;
        do_reset();

        // reset state
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_afull", 32'(almost_full), 0);
        chk("rst_q", 32'(q), 0);
        chk("rst_qvld", 32'(q_vld), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);

        // write 0x11..0x14, read four back
        for (int i = 0; i < 4; i++) tick(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
        chk("w4_count", 32'(count), 4);
        chk("w4_aempty", 32'(almost_empty), 0);
        got.delete();
        for (int i = 0; i < 4; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("r4_empty", 32'(empty), 1);
        for (int i = 1; i < LAT; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        exp4 = '{8'h11, 8'h12, 8'h13, 8'h14};
        chk("r4_n", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("r4_data", 32'(got[i]), 32'(exp4[i]));
        tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("r4_qhold", 32'(q), 32'h14);
        chk("r4_qvld_lo", 32'(q_vld), 0);

        // fill to 32, watching almost flags
        for (int i = 0; i < 32; i++) begin
            tick(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
            if (i == 1)  chk("ae_at2", 32'(almost_empty), 1);
            if (i == 2)  chk("ae_at3", 32'(almost_empty), 0);
            if (i == 28) chk("af_at29", 32'(almost_full), 0);
            if (i == 29) chk("af_at30", 32'(almost_full), 1);
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_count", 32'(count), 32);
        chk("fill_ovf0", 32'(overflow), 0);
        tick(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("w33_ovf", 32'(overflow), 1);
        chk("w33_count", 32'(count), 32);

        // full with wren+rden: read wins, write dropped
        got.delete();
        tick(1'b1, 8'hDD, 1'b1, 1'b0);
        chk("fullrw_count", 32'(count), 31);
        chk("fullrw_ovf", 32'(overflow), 1);
        chk("fullrw_full", 32'(full), 0);
        for (int i = 0; i < 31; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i < LAT; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("drain_n", 32'(got.size()), 32);
        for (int i = 0; i < 32 && i < got.size(); i++) chk("drain_data", 32'(got[i]), 32'h40 + i);
        chk("drain_empty", 32'(empty), 1);

        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 0);

        // empty with rden+wren: write wins, read rejected
        tick(1'b1, 8'h5A, 1'b1, 1'b0);
        chk("emprw_udf", 32'(underflow), 1);
        chk("emprw_count", 32'(count), 1);
        for (int i = 1; i < LAT; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("emprw_qvld", 32'(q_vld), 0);
        got.delete();
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i < LAT; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("emprw_rd", 32'(got.size() == 1 ? got[0] : 8'h00), 32'h5A);

        // err_clr coinciding with a new underflow: set wins
        tick(1'b0, 8'h00, 1'b1, 1'b1);
        chk("clrset_udf", 32'(underflow), 1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_udf", 32'(underflow), 0);

        // random traffic
        n_wr_acc = 0; n_rd_acc = 0;
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 5);
        chk("rand_rdwrap", 32'(n_rd_acc >= 160), 1);
        chk("rand_wrwrap", 32'(n_wr_acc >= 160), 1);
        tick(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rand_clr_ovf", 32'(overflow), 0);
        chk("rand_clr_udf", 32'(underflow), 0);

        // reset with 7 entries and a pending error
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 27; i++) tick(1'b1, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_ovf", 32'(overflow), 1);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 22; i++) tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_count", 32'(count), 7);
        do_reset();
        chk("mrst_count", 32'(count), 0);
        chk("mrst_empty", 32'(empty), 1);
        chk("mrst_q", 32'(q), 0);
        chk("mrst_qvld", 32'(q_vld), 0);
        chk("mrst_ovf", 32'(overflow), 0);
        chk("mrst_udf", 32'(underflow), 0);
        sb_checks();
        got.delete();
        tick(1'b1, 8'hC3, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 1; i < LAT; i++) tick(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_rd", 32'(got.size() == 1 ? got[0] : 8'h00), 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
